// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared command encodings, FSM states and defaults for the memory access controller
package mem_ctrl_pkg;
  localparam logic [1:0] CNTRL_IDLE  = 2'b00;
  localparam logic [1:0] CNTRL_READ  = 2'b01;
  localparam logic [1:0] CNTRL_WRITE = 2'b10;
  localparam int TIMEOUT_DEFAULT    = 64;
  localparam int FIFO_DEPTH_DEFAULT = 2;
  localparam int REQ_W              = 26;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;
  typedef struct packed {
    logic        we;
    logic        ind;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } req_t;
endpackage

// File: rtl/req_fifo.sv
// req_fifo: small request buffer with registered occupancy count; push and pop may share a cycle
module req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign o_full  = r_cnt == CW'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  // pointer and occupancy tracking; a full buffer still accepts a push when the head leaves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= nxt(r_wr_ptr);
      if (w_pop) r_rd_ptr <= nxt(r_rd_ptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // entry storage needs no reset: only slots covered by the count are ever read
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_data;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: buffers CPU requests and sequences them one at a time onto a handshaked memory port
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_ind,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [15:0] cpu_rdata,
  output logic [1:0]  cntrl,
  output logic [7:0]  addr,
  output logic        isIndirect,
  output logic [15:0] dataIn,
  input  logic [15:0] dataOut,
  input  logic        dataReady
);
  localparam int CW = $clog2(TIMEOUT) + 1;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  req_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  assign cpu_ack = cpu_req & ~w_full & rst_n;
  assign w_pop   = (r_state == ST_IDLE) & ~w_empty;
  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (cpu_ack),
    .i_data  ({cpu_we, cpu_ind, cpu_addr, cpu_wdata}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
  // access sequencer: issue head, hold command until dataReady or timeout, then one idle release cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      cntrl      <= CNTRL_IDLE;
      addr       <= '0;
      isIndirect <= 1'b0;
      dataIn     <= '0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_pop) begin
            cntrl      <= w_head.we ? CNTRL_WRITE : CNTRL_READ;
            addr       <= w_head.addr;
            isIndirect <= w_head.ind;
            dataIn     <= w_head.wdata;
            r_cnt      <= '0;
            r_state    <= ST_ACCESS;
          end
        ST_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (dataReady) begin
            cpu_done <= 1'b1;
            cpu_err  <= 1'b0;
            if (cntrl == CNTRL_READ) cpu_rdata <= dataOut;
            cntrl    <= CNTRL_IDLE;
            r_state  <= ST_RELEASE;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            cpu_done  <= 1'b1;
            cpu_err   <= 1'b1;
            cpu_rdata <= '0;
            cntrl     <= CNTRL_IDLE;
            r_state   <= ST_RELEASE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random request sequences checked against an in-order transaction model
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        cpu_req = 0;
  logic        cpu_we = 0;
  logic        cpu_ind = 0;
  logic [7:0]  cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic        cpu_ack;
  logic        cpu_done;
  logic        cpu_err;
  logic [15:0] cpu_rdata;
  logic [1:0]  cntrl;
  logic [7:0]  addr;
  logic        isIndirect;
  logic [15:0] dataIn;
  logic [15:0] dataOut = 0;
  logic        dataReady = 0;
  typedef struct {
    logic        we;
    logic        ind;
    logic [7:0]  a;
    logic [15:0] d;
  } txn_t;
  txn_t        exp_q[$];
  logic [15:0] tb_mem [256];
  logic [15:0] last_rdata = 0;
  logic [1:0]  prev_cntrl = 0;
  int          checks = 0;
  int          errors = 0;
  int          n_buf = 0;
  int          acc_ticks = 0;
  int          rdy_at = -1;
  int          lat = 2;
  bit          stall = 0;
  bit          force_rdy = 0;
  bit          accepted = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(8), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_ind    (cpu_ind),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_done   (cpu_done),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .cntrl      (cntrl),
    .addr       (addr),
    .isIndirect (isIndirect),
    .dataIn     (dataIn),
    .dataOut    (dataOut),
    .dataReady  (dataReady)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    txn_t e;
    #2;
    accepted = cpu_ack;
    chk("ack", cpu_ack, cpu_req && n_buf < 2);
    if (accepted) begin
      exp_q.push_back('{cpu_we, cpu_ind, cpu_addr, cpu_wdata});
      n_buf++;
    end
    @(posedge clk);
    #1;
    if (cpu_done) begin
      chk("done_pending", exp_q.size() > 0, 1);
      chk("done_cntrl", cntrl, CNTRL_IDLE);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("err", cpu_err, rdy_at < 0);
        chk("acc_cycles", acc_ticks, rdy_at < 0 ? 8 : rdy_at + 1);
        if (rdy_at < 0) last_rdata = 16'h0000;
        else if (e.we) tb_mem[e.a] = e.d;
        else last_rdata = tb_mem[e.a];
        chk("rdata", cpu_rdata, last_rdata);
      end
      acc_ticks = 0;
      rdy_at = -1;
    end
    if (cntrl != CNTRL_IDLE) begin
      if (prev_cntrl == CNTRL_IDLE) n_buf--;
      chk("issue_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("cntrl", cntrl, e.we ? CNTRL_WRITE : CNTRL_READ);
        chk("addr", addr, e.a);
        chk("ind", isIndirect, e.ind);
        if (e.we) chk("dataIn", dataIn, e.d);
      end
      acc_ticks++;
    end
    prev_cntrl = cntrl;
    dataOut = tb_mem[addr];
    dataReady = force_rdy || (cntrl != CNTRL_IDLE && !stall && acc_ticks > lat);
    if (cntrl != CNTRL_IDLE && dataReady && rdy_at < 0) rdy_at = acc_ticks - 1;
  endtask

  task automatic send(input logic we, input logic ind, input logic [7:0] a, input logic [15:0] d);
    cpu_req = 1;
    cpu_we = we;
    cpu_ind = ind;
    cpu_addr = a;
    cpu_wdata = d;
    accepted = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (accepted) break;
    end
    chk("send_accepted", accepted, 1);
    cpu_req = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    chk("drain", exp_q.size(), 0);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 16'(i * 257) ^ 16'h5A5A;
    tb_mem[8'h3C] = 16'hFFC3;
    #1 rst_n = 0;
    cpu_req = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", cpu_ack, 0);
    chk("rst_cntrl", cntrl, CNTRL_IDLE);
    chk("rst_addr", addr, 0);
    chk("rst_ind", isIndirect, 0);
    chk("rst_dataIn", dataIn, 0);
    chk("rst_done", cpu_done, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    cpu_req = 0;
    #3 rst_n = 1;
    tick();
    tick();
    lat = 3;
    send(0, 0, 8'h3C, 16'h0000);
    drain();
    chk("read_3c", cpu_rdata, 16'hFFC3);
    lat = 4;
    send(1, 1, 8'h05, 16'hA5A5);
    drain();
    chk("write_keeps_rdata", cpu_rdata, 16'hFFC3);
    stall = 1;
    send(0, 0, 8'h01, 16'h0000);
    send(0, 1, 8'h02, 16'h0000);
    send(1, 0, 8'h03, 16'h1234);
    cpu_req = 1;
    cpu_addr = 8'h04;
    cpu_we = 0;
    tick();
    tick();
    chk("full_noack", cpu_ack, 0);
    stall = 0;
    lat = 1;
    send(0, 0, 8'h04, 16'h0000);
    drain();
    stall = 1;
    send(0, 0, 8'h77, 16'h0000);
    drain();
    chk("timeout_rdata", cpu_rdata, 16'h0000);
    stall = 0;
    lat = 2;
    send(0, 0, 8'h3C, 16'h0000);
    drain();
    chk("after_timeout", cpu_rdata, 16'hFFC3);
    lat = 7;
    send(0, 1, 8'h03, 16'h0000);
    drain();
    force_rdy = 1;
    repeat (3) tick();
    chk("idle_rdy_no_done", cpu_done, 0);
    chk("idle_rdy_cntrl", cntrl, CNTRL_IDLE);
    send(0, 0, 8'h05, 16'h0000);
    drain();
    force_rdy = 0;
    dataReady = 0;
    stall = 1;
    send(0, 0, 8'h10, 16'h0000);
    send(0, 0, 8'h11, 16'h0000);
    tick();
    chk("pre_rst_cntrl", cntrl, CNTRL_READ);
    cpu_req = 1;
    cpu_addr = 8'h20;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_cntrl", cntrl, CNTRL_IDLE);
    chk("mid_rst_addr", addr, 0);
    chk("mid_rst_done", cpu_done, 0);
    chk("mid_rst_rdata", cpu_rdata, 0);
    chk("mid_rst_ack", cpu_ack, 0);
    cpu_req = 0;
    exp_q.delete();
    n_buf = 0;
    last_rdata = 0;
    acc_ticks = 0;
    rdy_at = -1;
    prev_cntrl = 0;
    stall = 0;
    dataReady = 0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1;
    repeat (4) tick();
    chk("queued_lost", cntrl, CNTRL_IDLE);
    lat = 2;
    send(0, 0, 8'h3C, 16'h0000);
    drain();
    chk("clean_after_rst", cpu_rdata, 16'hFFC3);
    for (int k = 0; k < 24; k++) begin
      lat = int'($urandom_range(0, 7));
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
